decoder_dense: RTL and testbench

DECODER_DENSE -- requirements
Module: decoder_dense

---
 rtl/decoder_dense_if.sv | 31 +++
 rtl/decoder_dense.sv | 188 ++++++++++++++++++
 tb/tb_decoder_dense.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/decoder_dense_if.sv
// Bus bundle for decoder_dense: input vector handshake, weight ROM port and
// the packed result vector with its completion/busy flags.
interface decoder_dense_if #(
    parameter int IN_NUM       = 32,
    parameter int NODE_NUM     = 64,
    parameter int IN_WIDTH     = 17,
    parameter int W_WIDTH      = 9,
    parameter int OUTPUT_WIDTH = 9
);
    localparam int A_W = $clog2(NODE_NUM * (IN_NUM + 1));

    logic                             valid;
    logic [IN_WIDTH*IN_NUM-1:0]       x;
    logic [A_W-1:0]                   w_addr;
    logic [W_WIDTH-1:0]               w_data;
    logic [OUTPUT_WIDTH*NODE_NUM-1:0] out;
    logic                             out_ready;
    logic                             busy;

    // Producer of vectors and owner of the weight ROM.
    modport master (
        output valid, x, w_data,
        input  w_addr, out, out_ready, busy
    );

    // The dense decoder layer itself.
    modport slave (
        input  valid, x, w_data,
        output w_addr, out, out_ready, busy
    );
endinterface

// File: rtl/decoder_dense.sv
// Dense (fully connected) decoder layer: one time-multiplexed signed MAC
// walks the weight ROM node by node, adds the bias, requantizes, saturates,
// optionally applies ReLU and stores each node result in its out slot.
module decoder_dense #(
    parameter int IN_NUM          = 32,
    parameter int NODE_NUM        = 64,
    parameter int IN_WIDTH        = 17,
    parameter int IN_FRACTION     = 14,
    parameter int W_WIDTH         = 9,
    parameter int W_FRACTION      = 7,
    parameter int OUTPUT_WIDTH    = 9,
    parameter int OUTPUT_FRACTION = 7,
    parameter int RELU            = 1
) (
    input  logic           clk,
    input  logic           rst,
    decoder_dense_if.slave bus
);
    localparam int TERMS  = NODE_NUM * (IN_NUM + 1);
    localparam int A_W    = $clog2(TERMS);
    localparam int K_W    = $clog2(IN_NUM + 1);
    localparam int N_W    = (NODE_NUM > 1) ? $clog2(NODE_NUM) : 1;
    localparam int PROD_W = IN_WIDTH + W_WIDTH;
    localparam int ACC_W  = PROD_W + K_W;
    localparam int SHIFT  = IN_FRACTION + W_FRACTION - OUTPUT_FRACTION;

    localparam logic signed [ACC_W-1:0] OUT_MAX = (ACC_W'(1) <<< (OUTPUT_WIDTH - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

    typedef enum logic [1:0] {IDLE, MAC, FLUSH, DONE} state_t;

    state_t                         state_q, state_d;
    logic                           start_q;
    logic                           accept;
    logic [A_W-1:0]                 addr_q, addr_d;
    logic [K_W-1:0]                 k_q, k_d;
    logic [N_W-1:0]                 n_q, n_d;
    logic [IN_WIDTH*IN_NUM-1:0]     x_q;

    logic                           vld_p1_q;
    logic [K_W-1:0]                 k_p1_q;
    logic [N_W-1:0]                 n_p1_q;

    logic signed [IN_WIDTH-1:0]     xsel;
    logic signed [W_WIDTH-1:0]      w_s;
    logic signed [PROD_W-1:0]       prod;
    logic signed [ACC_W-1:0]        term;
    logic signed [ACC_W-1:0]        sum;
    logic signed [ACC_W-1:0]        acc_q;
    logic [OUTPUT_WIDTH*NODE_NUM-1:0] out_q;

    // Floor-shift to the output fraction and clamp to the output range.
    function automatic logic signed [ACC_W-1:0] requant_sat(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] s;
        s = v >>> SHIFT;
        if (s > OUT_MAX) begin
            s = OUT_MAX;
        end else if (s < OUT_MIN) begin
            s = OUT_MIN;
        end
        return s;
    endfunction

    // Optional rectifier applied after saturation.
    function automatic logic [OUTPUT_WIDTH-1:0] activate(input logic signed [ACC_W-1:0] s);
        logic signed [ACC_W-1:0] r;
        r = s;
        if ((RELU != 0) && (s < 0)) begin
            r = '0;
        end
        return r[OUTPUT_WIDTH-1:0];
    endfunction

    // A vector is taken only in a truly idle cycle (no start already pending).
    assign accept = (state_q == IDLE) && !start_q && bus.valid;

    // State, address/term counters and the ROM-latency pipeline stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            start_q  <= 1'b0;
            addr_q   <= '0;
            k_q      <= '0;
            n_q      <= '0;
            vld_p1_q <= 1'b0;
            k_p1_q   <= '0;
            n_p1_q   <= '0;
        end else begin
            state_q  <= state_d;
            start_q  <= accept;
            addr_q   <= addr_d;
            k_q      <= k_d;
            n_q      <= n_d;
            // p1: ROM data for this term arrives in the next cycle
            vld_p1_q <= (state_q == MAC);
            k_p1_q   <= k_q;
            n_p1_q   <= n_q;
        end
    end

    // Next-state logic: one ROM address per MAC cycle, then drain and report.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        k_d     = k_q;
        n_d     = n_q;
        case (state_q)
            IDLE: begin
                addr_d = '0;
                k_d    = '0;
                n_d    = '0;
                if (start_q) begin
                    state_d = MAC;
                end
            end
            MAC: begin
                addr_d = addr_q + A_W'(1);
                if (k_q == K_W'(IN_NUM)) begin
                    k_d = '0;
                    n_d = n_q + N_W'(1);
                end else begin
                    k_d = k_q + K_W'(1);
                end
                if (addr_q == A_W'(TERMS - 1)) begin
                    state_d = FLUSH;
                    addr_d  = '0;
                    k_d     = '0;
                    n_d     = '0;
                end
            end
            FLUSH: state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Input vector is held from one acceptance to the next.
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            x_q <= bus.x;
        end
    end

    // Operand select, single multiplier, bias alignment and accumulate.
    always_comb begin
        xsel = '0;
        for (int i = 0; i < IN_NUM; i++) begin
            if (k_p1_q == K_W'(i)) begin
                xsel = x_q[i*IN_WIDTH +: IN_WIDTH];
            end
        end
        w_s  = bus.w_data;
        prod = PROD_W'(xsel) * PROD_W'(w_s);
        if (k_p1_q == K_W'(IN_NUM)) begin
            term = ACC_W'(w_s) <<< IN_FRACTION;
        end else begin
            term = ACC_W'(prod);
        end
        if (k_p1_q == '0) begin
            sum = term;
        end else begin
            sum = acc_q + term;
        end
    end

    // p2: accumulator update and write-back of each completed node.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            out_q <= '0;
        end else if (vld_p1_q) begin
            acc_q <= sum;
            if (k_p1_q == K_W'(IN_NUM)) begin
                for (int n = 0; n < NODE_NUM; n++) begin
                    if (n_p1_q == N_W'(n)) begin
                        out_q[n*OUTPUT_WIDTH +: OUTPUT_WIDTH] <= activate(requant_sat(sum));
                    end
                end
            end
        end
    end

    assign bus.w_addr    = (state_q == MAC) ? addr_q : '0;
    assign bus.out       = out_q;
    assign bus.out_ready = (state_q == DONE);
    assign bus.busy      = start_q || (state_q != IDLE);

endmodule

// File: tb/tb_decoder_dense.sv
// Bench for decoder_dense: small 2x2 layers (ReLU and linear) driven from a
// vector table plus multi-cycle corner sequences, and a default-size layer
// checked against a bit-exact integer reference model.
module tb_decoder_dense;
    localparam int SL     = 2 * (2 + 1) + 2;
    localparam int DTERMS = 64 * 33;
    localparam int DL     = DTERMS + 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decoder_dense_if #(.IN_NUM(2), .NODE_NUM(2)) bus_a ();
    decoder_dense_if #(.IN_NUM(2), .NODE_NUM(2)) bus_b ();
    decoder_dense_if bus_c ();

    decoder_dense #(.IN_NUM(2), .NODE_NUM(2), .RELU(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    decoder_dense #(.IN_NUM(2), .NODE_NUM(2), .RELU(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
    decoder_dense dut_c (.clk(clk), .rst(rst), .bus(bus_c));

    logic [8:0] rom_s [8];
    logic [8:0] rom_c [4096];

    // Synchronous weight ROMs: data one cycle after address
    always @(posedge clk) begin
        bus_a.w_data <= rom_s[bus_a.w_addr];
        bus_b.w_data <= rom_s[bus_b.w_addr];
        bus_c.w_data <= rom_c[bus_c.w_addr];
    end

    typedef struct {
        logic [33:0] x;
        logic [53:0] rom;
        logic [17:0] exp_relu;
        logic [17:0] exp_lin;
    } vec_t;

    typedef struct {
        logic [17:0] relu;
        logic [17:0] lin;
    } exp_t;

    vec_t tbl [5];
    exp_t sb [$];
    logic [575:0] sb_c [$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [16:0] x0, input logic [16:0] x1,
                                input logic [8:0] w00, input logic [8:0] w01, input logic [8:0] b0,
                                input logic [8:0] w10, input logic [8:0] w11, input logic [8:0] b1,
                                input logic [8:0] r0, input logic [8:0] r1,
                                input logic [8:0] l0, input logic [8:0] l1);
        vec_t v;
        v.x        = {x1, x0};
        v.rom      = {b1, w11, w10, b0, w01, w00};
        v.exp_relu = {r1, r0};
        v.exp_lin  = {l1, l0};
        return v;
    endfunction

    task automatic load_rom(input logic [53:0] r);
        for (int j = 0; j < 6; j++) rom_s[j] = r[j*9 +: 9];
        rom_s[6] = '0;
        rom_s[7] = '0;
    endtask

    // Drive one vector into both small DUTs and wait (bounded) for out_ready.
    task automatic run_op(input logic [33:0] xv, input int repulse_at, input logic [33:0] xalt,
                          input int rst_at, input int limit,
                          output int edges, output logic got, output logic busy0);
        @(negedge clk);
        bus_a.x = xv; bus_b.x = xv;
        bus_a.valid = 1'b1; bus_b.valid = 1'b1;
        @(negedge clk);
        bus_a.valid = 1'b0; bus_b.valid = 1'b0;
        edges = 0;
        got   = 1'b0;
        busy0 = bus_a.busy;
        while (!got && edges < limit) begin
            if (bus_a.out_ready) begin
                got = 1'b1;
            end else begin
                if (edges == repulse_at) begin
                    bus_a.valid = 1'b1; bus_b.valid = 1'b1;
                    bus_a.x = xalt; bus_b.x = xalt;
                end else begin
                    bus_a.valid = 1'b0; bus_b.valid = 1'b0;
                end
                rst = (edges == rst_at - 1);
                @(negedge clk);
                edges++;
            end
        end
        bus_a.valid = 1'b0; bus_b.valid = 1'b0;
        rst = 1'b0;
    endtask

    // Checks for a normally completing small-layer operation.
    task automatic check_done(input string tag, input int edges, input logic got, input logic busy0);
        exp_t e;
        chk({tag, "_ready"}, 64'(got), 64'(1));
        chk({tag, "_latency"}, 64'(edges), 64'(SL));
        chk({tag, "_busy_after_accept"}, 64'(busy0), 64'(1));
        chk({tag, "_busy_in_ready"}, 64'(bus_a.busy), 64'(1));
        chk({tag, "_ready_b"}, 64'(bus_b.out_ready), 64'(1));
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s_scoreboard actual=empty required=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_out_relu"}, 64'(bus_a.out), 64'(e.relu));
            chk({tag, "_out_lin"}, 64'(bus_b.out), 64'(e.lin));
        end
    endtask

    // Bit-exact reference for one node of the default-size layer (ReLU on).
    function automatic logic [8:0] ref_node(input logic [543:0] xv, input int n);
        longint acc;
        longint q;
        acc = 0;
        for (int k = 0; k < 32; k++) begin
            acc += longint'($signed(xv[k*17 +: 17])) * longint'($signed(rom_c[n*33 + k]));
        end
        acc += longint'($signed(rom_c[n*33 + 32])) * 64'sd16384;
        q = acc >>> 14;
        if (q > 255) q = 255;
        if (q < -256) q = -256;
        if (q < 0) q = 0;
        return q[8:0];
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int edges;
        logic got, busy0;
        exp_t e;
        logic [543:0] xc;
        logic [575:0] ec;
        logic [575:0] gc;
        int tmp;

        tbl[0] = mk(17'h04000, 17'h02000, 9'h040, 9'h020, 9'h000, 9'h1C0, 9'h040, 9'h010,
                    9'h050, 9'h000, 9'h050, 9'h1F0);
        tbl[1] = mk(17'h07FFF, 17'h07FFF, 9'h181, 9'h181, 9'h181, 9'h07F, 9'h07F, 9'h07F,
                    9'h000, 9'h0FF, 9'h100, 9'h0FF);
        tbl[2] = mk(17'h04000, 17'h00000, 9'h1C0, 9'h0AB, 9'h000, 9'h001, 9'h0FF, 9'h000,
                    9'h000, 9'h001, 9'h1C0, 9'h001);
        tbl[3] = mk(17'h00001, 17'h1FFFF, 9'h001, 9'h000, 9'h000, 9'h000, 9'h001, 9'h000,
                    9'h000, 9'h000, 9'h000, 9'h1FF);
        tbl[4] = mk(17'h04000, 17'h02000, 9'h000, 9'h000, 9'h0FF, 9'h000, 9'h000, 9'h100,
                    9'h0FF, 9'h000, 9'h0FF, 9'h100);

        rst = 1'b1;
        bus_a.valid = 1'b0; bus_b.valid = 1'b0; bus_c.valid = 1'b0;
        bus_a.x = '0; bus_b.x = '0; bus_c.x = '0;
        for (int j = 0; j < 8; j++) rom_s[j] = '0;
        for (int j = 0; j < 4096; j++) rom_c[j] = '0;
        repeat (3) @(negedge clk);
        chk("reset_out", 64'(bus_a.out), 64'(0));
        chk("reset_out_ready", 64'(bus_a.out_ready), 64'(0));
        chk("reset_busy", 64'(bus_a.busy), 64'(0));
        chk("reset_w_addr", 64'(bus_a.w_addr), 64'(0));
        chk("reset_out_c", 64'(bus_c.out[63:0]), 64'(0));
        rst = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < 5; i++) begin
            load_rom(tbl[i].rom);
            e.relu = tbl[i].exp_relu;
            e.lin  = tbl[i].exp_lin;
            sb.push_back(e);
            run_op(tbl[i].x, -1, '0, -1, SL + 8, edges, got, busy0);
            check_done($sformatf("vec%0d", i), edges, got, busy0);
            @(negedge clk);
            chk($sformatf("vec%0d_busy_cleared", i), 64'(bus_a.busy), 64'(0));
            chk($sformatf("vec%0d_w_addr_idle", i), 64'(bus_a.w_addr), 64'(0));
        end

        // valid re-pulsed while busy, and valid offered in the DONE cycle
        load_rom(tbl[0].rom);
        e.relu = tbl[0].exp_relu;
        e.lin  = tbl[0].exp_lin;
        sb.push_back(e);
        run_op(tbl[0].x, 3, tbl[1].x, -1, SL + 8, edges, got, busy0);
        check_done("repulse", edges, got, busy0);
        bus_a.valid = 1'b1; bus_b.valid = 1'b1;
        @(negedge clk);
        bus_a.valid = 1'b0; bus_b.valid = 1'b0;
        chk("done_valid_ignored_busy", 64'(bus_a.busy), 64'(0));
        chk("done_valid_ignored_ready", 64'(bus_a.out_ready), 64'(0));
        @(negedge clk);
        chk("done_valid_not_started", 64'(bus_a.busy), 64'(0));

        // Reset at edge 4 of an operation aborts it
        load_rom(tbl[1].rom);
        run_op(tbl[1].x, -1, '0, 4, SL + 8, edges, got, busy0);
        chk("abort_no_ready", 64'(got), 64'(0));
        chk("abort_out_a", 64'(bus_a.out), 64'(0));
        chk("abort_out_b", 64'(bus_b.out), 64'(0));
        chk("abort_busy", 64'(bus_a.busy), 64'(0));
        e.relu = tbl[1].exp_relu;
        e.lin  = tbl[1].exp_lin;
        sb.push_back(e);
        run_op(tbl[1].x, -1, '0, -1, SL + 8, edges, got, busy0);
        check_done("after_abort", edges, got, busy0);

        // Reset wins over a simultaneous valid
        @(negedge clk);
        rst = 1'b1;
        bus_a.valid = 1'b1; bus_b.valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus_a.valid = 1'b0; bus_b.valid = 1'b0;
        chk("rst_vs_valid_busy", 64'(bus_a.busy), 64'(0));
        @(negedge clk);
        chk("rst_vs_valid_no_start", 64'(bus_a.busy), 64'(0));

        // Default-size layer against the reference model
        for (int t = 0; t < 2; t++) begin
            for (int j = 0; j < DTERMS; j++) begin
                if ((j % 33) == 32) tmp = int'($urandom_range(0, 127)) - 64;
                else                tmp = int'($urandom_range(0, 31)) - 16;
                rom_c[j] = tmp[8:0];
            end
            for (int k = 0; k < 32; k++) begin
                tmp = int'($urandom_range(0, 32768)) - 16384;
                xc[k*17 +: 17] = tmp[16:0];
            end
            for (int n = 0; n < 64; n++) ec[n*9 +: 9] = ref_node(xc, n);
            sb_c.push_back(ec);
            @(negedge clk);
            bus_c.x = xc;
            bus_c.valid = 1'b1;
            @(negedge clk);
            bus_c.valid = 1'b0;
            edges = 0;
            got = 1'b0;
            while (!got && edges < DL + 20) begin
                if (bus_c.out_ready) got = 1'b1;
                else begin
                    @(negedge clk);
                    edges++;
                end
            end
            chk($sformatf("dflt%0d_ready", t), 64'(got), 64'(1));
            chk($sformatf("dflt%0d_latency", t), 64'(edges), 64'(DL));
            ec = sb_c.pop_front();
            gc = bus_c.out;
            for (int n = 0; n < 64; n++) begin
                chk($sformatf("dflt%0d_node%0d", t, n), 64'(gc[n*9 +: 9]), 64'(ec[n*9 +: 9]));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
